// File: rtl/interboard_rx_frame_if.sv
// Inter-board receive link bundle: peer handshake plus decoded-message outputs.
// "master" is the peer/consumer side, "slave" is the receiver block.
interface interboard_rx_frame_if;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       interboard_en;
  logic       interboard_rst;
  logic [3:0] interboard_msg_type;
  logic       interboard_move_dir;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;
  logic       frame_err;
  logic       busy;

  modport master (
    output Request_in, inter_data_in,
    input  Ack_out, interboard_en, interboard_rst, interboard_msg_type,
           interboard_move_dir, interboard_block_x, interboard_block_y,
           interboard_card, interboard_sel_len, frame_err, busy
  );

  modport slave (
    input  Request_in, inter_data_in,
    output Ack_out, interboard_en, interboard_rst, interboard_msg_type,
           interboard_move_dir, interboard_block_x, interboard_block_y,
           interboard_card, interboard_sel_len, frame_err, busy
  );
endinterface

// File: rtl/interboard_rx_frame.sv
// Receive side of the inter-board link: four-phase Request/Ack word capture,
// 4-word frame reassembly, field decode and mid-frame timeout recovery.
module interboard_rx_frame #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [3:0]  RST_MSG_TYPE   = 4'd15
) (
  input logic                  clk,
  input logic                  rst,
  interboard_rx_frame_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    ACK_HI   = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          req_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] tmo_q;
  logic [23:0]   sh_q;
  logic          ack_q;
  logic          busy_q;
  logic          en_q;
  logic          rstmsg_q;
  logic          err_q;
  logic [3:0]    msg_type_q;
  logic          move_dir_q;
  logic [4:0]    block_x_q;
  logic [2:0]    block_y_q;
  logic [5:0]    card_q;
  logic [2:0]    sel_len_q;
  logic [23:0]   sh_d;

  assign sh_d = {sh_q[17:0], bus.inter_data_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      req_q      <= 1'b0;
      idx_q      <= 2'd0;
      tmo_q      <= '0;
      sh_q       <= 24'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      rstmsg_q   <= 1'b0;
      err_q      <= 1'b0;
      msg_type_q <= 4'd0;
      move_dir_q <= 1'b0;
      block_x_q  <= 5'd0;
      block_y_q  <= 3'd0;
      card_q     <= 6'd0;
      sel_len_q  <= 3'd0;
    end else begin
      sync1_q  <= bus.Request_in;
      req_q    <= sync1_q;
      en_q     <= 1'b0;
      rstmsg_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q <= 2'd0;
          tmo_q <= '0;
          if (req_q) begin
            sh_q    <= sh_d;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ACK_HI;
          end else begin
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        WAIT_REQ: begin
          if (req_q) begin
            sh_q    <= sh_d;
            ack_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ACK_HI;
          end else if (tmo_q == TMO_LAST) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= FLUSH;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ACK_HI: begin
          // A completed handshake wins over a timeout landing on the same edge.
          if (!req_q) begin
            ack_q <= 1'b0;
            tmo_q <= '0;
            if (idx_q != 2'd3) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= WAIT_REQ;
            end else begin
              idx_q   <= 2'd0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
              if (sh_q[1:0] == 2'b00) begin
                msg_type_q <= sh_q[23:20];
                move_dir_q <= sh_q[19];
                block_x_q  <= sh_q[18:14];
                block_y_q  <= sh_q[13:11];
                card_q     <= sh_q[10:5];
                sel_len_q  <= sh_q[4:2];
                en_q       <= 1'b1;
                rstmsg_q   <= (sh_q[23:20] == RST_MSG_TYPE);
              end else begin
                err_q <= 1'b1;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= FLUSH;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        FLUSH: begin
          ack_q <= 1'b0;
          tmo_q <= '0;
          if (!req_q) begin
            busy_q  <= 1'b0;
            idx_q   <= 2'd0;
            state_q <= IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= 2'd0;
          tmo_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ack_out             = ack_q;
  assign bus.busy                = busy_q;
  assign bus.interboard_en       = en_q;
  assign bus.interboard_rst      = rstmsg_q;
  assign bus.frame_err           = err_q;
  assign bus.interboard_msg_type = msg_type_q;
  assign bus.interboard_move_dir = move_dir_q;
  assign bus.interboard_block_x  = block_x_q;
  assign bus.interboard_block_y  = block_y_q;
  assign bus.interboard_card     = card_q;
  assign bus.interboard_sel_len  = sel_len_q;

endmodule

// File: tb/tb_interboard_rx_frame.sv
// Randomized self-checking bench for interboard_rx_frame: a peer driver feeds
// frames while a per-cycle monitor compares the DUT against a behavioural model.
module tb_interboard_rx_frame;
  localparam int unsigned TMO = 64;

  logic clk;
  logic rst;
  interboard_rx_frame_if bus ();

  interboard_rx_frame #(.TIMEOUT_CYCLES(TMO), .RST_MSG_TYPE(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected strobes, busy and the last valid frame's fields.
  bit          exp_en = 1'b0, exp_rst = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [21:0] exp_fields = 22'd0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] dut_fields();
    return {bus.interboard_msg_type, bus.interboard_move_dir, bus.interboard_block_x,
            bus.interboard_block_y, bus.interboard_card, bus.interboard_sel_len};
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("en",     bus.interboard_en,  exp_en);
    chk("rstmsg", bus.interboard_rst, exp_rst);
    chk("err",    bus.frame_err,      exp_err);
    chk("busy",   bus.busy,           exp_busy);
    chk("fields", dut_fields(),       exp_fields);
    chk("en_err_excl", bus.interboard_en & bus.frame_err, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One four-phase word; returns right after Ack is seen falling.
  task automatic send_word(input logic [5:0] w, input bit first, input int hold);
    int n;
    bus.inter_data_in = w;
    bus.Request_in    = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.Ack_out && n < 50);
    chk("ack_rise_lat", n, 3);
    if (first) exp_busy = 1'b1;
    repeat (hold) tick();
    bus.Request_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.Ack_out && n < 50);
    chk("ack_fall_lat", n, 3);
  endtask

  // Full frame; model derives the fields from the 24-bit value arithmetically.
  task automatic send_frame(input logic [23:0] f);
    int fv;
    int holds[4];
    for (int i = 0; i < 4; i++) holds[i] = $urandom_range(0, 6);
    fv = int'(f);
    for (int i = 0; i < 4; i++) begin
      send_word(6'((fv >> (18 - 6 * i)) % 64), i == 0, holds[i]);
      if (i < 3) repeat ($urandom_range(0, 6)) tick();
    end
    exp_busy = 1'b0;
    if (fv % 4 == 0) begin
      exp_en     = 1'b1;
      exp_rst    = ((fv / (1 << 20)) == 15);
      exp_fields = 22'(fv / 4);
    end else begin
      exp_err = 1'b1;
    end
    tick();
    exp_en  = 1'b0;
    exp_rst = 1'b0;
    exp_err = 1'b0;
    repeat ($urandom_range(0, 4)) tick();
  endtask

  function automatic logic [23:0] words4(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] c, input logic [5:0] d);
    return {a, b, c, d};
  endfunction

  initial begin
    logic [23:0] f;
    bus.Request_in    = 1'b0;
    bus.inter_data_in = 6'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ack", bus.Ack_out, 0);
    chk("reset_fields", dut_fields(), 0);

    send_frame(words4(6'h0F, 6'h06, 6'h35, 6'h0C));
    chk("d1_msg_type", bus.interboard_msg_type, 3);
    chk("d1_move_dir", bus.interboard_move_dir, 1);
    chk("d1_block_x",  bus.interboard_block_x, 17);
    chk("d1_block_y",  bus.interboard_block_y, 5);
    chk("d1_card",     bus.interboard_card, 42);
    chk("d1_sel_len",  bus.interboard_sel_len, 3);

    send_frame(words4(6'h0F, 6'h06, 6'h35, 6'h0D));
    chk("resv_keeps_card", bus.interboard_card, 42);

    send_frame(words4(6'h3C, 6'h00, 6'h00, 6'h00));
    chk("rstmsg_msg_type", bus.interboard_msg_type, 15);
    chk("rstmsg_card",     bus.interboard_card, 0);

    // Stall after word0: abort 64 cycles into WAIT_REQ, busy drops one cycle later.
    send_word(6'h2A, 1'b1, 2);
    repeat (TMO - 1) tick();
    tick();
    exp_err = 1'b1;
    tick();
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    repeat (3) tick();
    send_frame(words4(6'h0F, 6'h06, 6'h35, 6'h0C));
    chk("post_tmo_block_x", bus.interboard_block_x, 17);

    // Async reset while Ack is high mid-frame.
    send_word(6'h11, 1'b1, 1);
    bus.inter_data_in = 6'h22;
    bus.Request_in    = 1'b1;
    repeat (3) tick();
    chk("pre_rst_ack", bus.Ack_out, 1);
    rst        = 1'b1;
    exp_busy   = 1'b0;
    exp_fields = 22'd0;
    #1;
    chk("rst_ack",    bus.Ack_out, 0);
    chk("rst_fields", dut_fields(), 0);
    chk("rst_busy",   bus.busy, 0);
    bus.Request_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    send_frame(words4(6'h0F, 6'h06, 6'h35, 6'h0C));
    chk("post_rst_sel_len", bus.interboard_sel_len, 3);

    for (int k = 0; k < 30; k++) begin
      f[23:20] = (k % 7 == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      f[19:2]  = 18'($urandom);
      f[1:0]   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(f);
    end

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
